counter_snap_arb: RTL
=====================

// Module: counter_snap_arb
// PURPOSE
//  Shares one destination-domain counter (the synchronized output of the counter CDC) among NREQ requesters.
//  Each request captures the counter and returns the value plus the modular delta since that requester's previous snapshot.
//  Round-robin arbitration; one snapshot in flight at a time.
//  Sits in the clk_dst domain, directly after the counter CDC.
// PARAMETERS
//  BITS       20    counter width; matches the counter CDC BITS
//  NREQ       4     number of requesters, 2..16
//  MAX_DELTA  4096  largest legal delta between snapshots; used only with COUNTER_SNAP_MONO_CHECK_EN
// PORTS
//  clk         in   1                 clock (clk_dst domain)
//  rst         in   1                 synchronous reset, active-high
//  counter_in  in   BITS              synchronized counter value
//  req         in   NREQ              level request per requester
//  clear       in   NREQ              1-cycle pulse; forgets that requester's base snapshot
//  ack         out  NREQ              one-hot, 1-cycle grant-complete pulse
//  snap_valid  out  1                 1-cycle pulse; snap_* fields are valid
//  snap_id     out  $clog2(NREQ)      index of the served requester
//  snap_value  out  BITS              captured counter_in
//  snap_delta  out  BITS              (snap_value - base[id]) mod 2^BITS
//  snap_first  out  1                 no base existed for this requester; snap_delta = 0
//  snap_err    out  1                 monotonic-check failure (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
//  - Reset values: all outputs 0, FSM in IDLE, rr_ptr = 0, all base_vld = 0.
//  - FSM states: IDLE -> CAPT -> RESP -> IDLE. It advances on every clock edge; there are no stalls.
//  - IDLE, req == 0: stay in IDLE.
//  - IDLE, req != 0: the grant is the first set req bit searching from rr_ptr upward, with wrap.
//    - Register gnt_id; next state is CAPT.
//  - CAPT: cap <= counter_in; next state is RESP.
//  - RESP: register the outputs for exactly 1 cycle:
//    - ack[gnt_id] = 1 and snap_valid = 1
//    - snap_value = cap
//    - snap_delta and snap_first as defined in PORTS
//  - RESP state update:
//    - base[gnt_id] <= cap and base_vld[gnt_id] <= 1
//    - rr_ptr <= (gnt_id + 1) mod NREQ
//    - next state is IDLE
//  - Latency: req is sampled high in IDLE at edge N; ack and snap_valid are high in the cycle after edge N+2.
//  - Throughput: at most 1 snapshot per 3 cycles.
//  - req is level-sensitive; each ack consumes one request.
//    - A requester that holds req high through ack is re-requesting; it is re-eligible at the next IDLE.
//    - Round-robin still serves the other pending requesters first.
//  - req deasserted after its grant (i.e., while in CAPT or RESP): the snapshot still completes and ack is issued.
//  - Delta arithmetic: BITS-wide subtract, wrap allowed. Example: base = 0xFFFF0, cap = 0x00010 -> delta = 0x00020.
//  - clear[i] sets base_vld[i] = 0 and has priority over the RESP update of the same index in the same cycle.
//    - The snapshot itself is still output.
//    - The next snapshot for i reports snap_first = 1.
//  - rst asserted mid-operation: the transaction is aborted, no ack is issued, and everything returns to reset values.
//  - counter_in is treated as stable per cycle; this block adds no synchronization.
// CONFIGURATION
//  COUNTER_SNAP_MONO_CHECK_EN defined:
//  - snap_err = snap_valid & ~snap_first & (snap_delta > MAX_DELTA).
//  - This flags CDC glitches or counter jumps.
//  COUNTER_SNAP_MONO_CHECK_EN not defined:
//  - The snap_err port remains and is tied to 0.
//  - MAX_DELTA is unused and no comparator is built.
// TESTING
//  1. Reset, then req = 4'b0001 for one cycle, counter_in = 100 -> ack = 0001 and snap_valid 3 cycles later.
//     Response: snap_id = 0, snap_value = 100, snap_first = 1, snap_delta = 0.
//  2. Repeat on req0 with counter_in = 350 -> snap_first = 0, snap_delta = 250.
//  3. req = 4'b1111 held -> grants in order 0, 1, 2, 3, 0, ...
//     One ack per 3 cycles, no requester starved.
//  4. Wrap: base = 0xFFFF0, then counter_in = 0x00010 -> snap_delta = 0x00020; snap_err = 0 with the macro defined.
//  5. clear[2] pulsed in the RESP cycle of requester 2 -> the output is still valid.
//     Next snapshot for requester 2: snap_first = 1.
//  6. rst asserted in CAPT -> no ack; all outputs 0 and rr_ptr = 0 afterwards.
//     With the macro defined, delta 5000 > MAX_DELTA -> snap_err = 1 for 1 cycle.

Source files
------------

// File: rtl/counter_snap_arb.sv
// counter_snap_arb: round-robin snapshot server for a shared counter; optional delta check via COUNTER_SNAP_MONO_CHECK_EN
module counter_snap_arb #(
    parameter int BITS      = 20,
    parameter int NREQ      = 4,
    parameter int MAX_DELTA = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BITS-1:0]         counter_in_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         clear_i,
    output logic [NREQ-1:0]         ack_o,
    output logic                    snap_valid_o,
    output logic [$clog2(NREQ)-1:0] snap_id_o,
    output logic [BITS-1:0]         snap_value_o,
    output logic [BITS-1:0]         snap_delta_o,
    output logic                    snap_first_o,
    output logic                    snap_err_o
);
    localparam int IDW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;
    state_t          state_q, state_d;
    logic [IDW-1:0]  gnt_q, gnt_d, rr_q, rr_d, pick;
    logic [BITS-1:0] cap_q, cap_d;
    logic [BITS-1:0] base_q [NREQ];
    logic [BITS-1:0] base_d [NREQ];
    logic [NREQ-1:0] base_vld_q, base_vld_d;
    logic            found;
    logic [NREQ-1:0] ack_d;
    logic            valid_d, first_d, err_d;
    logic [IDW-1:0]  id_d;
    logic [BITS-1:0] value_d, delta_d;
    // state, arbitration and snapshot registers; every output is a 1-cycle registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rr_q         <= '0;
            cap_q        <= '0;
            base_vld_q   <= '0;
            for (int i = 0; i < NREQ; i++) base_q[i] <= '0;
            ack_o        <= '0;
            snap_valid_o <= 1'b0;
            snap_id_o    <= '0;
            snap_value_o <= '0;
            snap_delta_o <= '0;
            snap_first_o <= 1'b0;
            snap_err_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            cap_q        <= cap_d;
            base_vld_q   <= base_vld_d;
            base_q       <= base_d;
            ack_o        <= ack_d;
            snap_valid_o <= valid_d;
            snap_id_o    <= id_d;
            snap_value_o <= value_d;
            snap_delta_o <= delta_d;
            snap_first_o <= first_d;
            snap_err_o   <= err_d;
        end
    end
    // round-robin pick, IDLE->CAPT->RESP sequencing and response formation
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        cap_d      = cap_q;
        base_d     = base_q;
        base_vld_d = base_vld_q;
        ack_d      = '0;
        valid_d    = 1'b0;
        id_d       = '0;
        value_d    = '0;
        delta_d    = '0;
        first_d    = 1'b0;
        found      = 1'b0;
        pick       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_q) + k) % NREQ);
            end
        end
        case (state_q)
            IDLE: begin
                gnt_d   = found ? pick : gnt_q;
                state_d = found ? CAPT : IDLE;
            end
            CAPT: begin
                cap_d   = counter_in_i;
                state_d = RESP;
            end
            RESP: begin
                ack_d[gnt_q]      = 1'b1;
                valid_d           = 1'b1;
                id_d              = gnt_q;
                value_d           = cap_q;
                first_d           = ~base_vld_q[gnt_q];
                delta_d           = first_d ? '0 : cap_q - base_q[gnt_q];
                base_d[gnt_q]     = cap_q;
                base_vld_d[gnt_q] = 1'b1;
                rr_d              = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        base_vld_d = base_vld_d & ~clear_i;
`ifdef COUNTER_SNAP_MONO_CHECK_EN
        err_d = valid_d & ~first_d & (delta_d > BITS'(MAX_DELTA));
`else
        err_d = 1'b0 & (MAX_DELTA < 0);
`endif
    end
endmodule
